// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage of the RISC-V datapath. Owns the program counter, drives the
// word address to instruction memory, captures the returned word into an
// IF/ID output register and offers it to decode over a valid/ready handshake.
// Handles sequential advance, branch/jump redirect with flush, decode
// back-pressure, halt on a designated instruction and misaligned targets.
//
// Parameters
//   RESET_PC   PC value loaded on reset
//   HALT_INSN  instruction encoding that stops fetch
//
// Ports
//   clk             in   1   clock, rising-edge
//   reset           in   1   synchronous, active-high reset
//   A               out  32  instruction-memory byte address (= pc)
//   RD              in   32  instruction-memory read data (combinational from A)
//   redirect_valid  in   1   branch/jump taken this cycle
//   redirect_pc     in   32  redirect target byte address
//   out_valid       out  1   IF/ID register holds a valid instruction
//   out_ready       in   1   decode accepts the instruction this cycle
//   out_instr       out  32  captured instruction
//   out_pc          out  32  pc of captured instruction
//   halted          out  1   fetch stopped
//   misaligned      out  1   sticky: a redirect target was not word aligned
//   fetch_count     out  32  instructions captured since reset
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_INSN = 32'h0000_0073
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] A,
  input  logic [31:0] RD,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted,
  output logic        misaligned,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_out_valid;
  logic [31:0] r_out_instr;
  logic [31:0] r_out_pc;
  logic        r_misaligned;
  logic [31:0] r_fetch_count;

  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic        w_out_valid_nxt;
  logic [31:0] w_out_instr_nxt;
  logic [31:0] w_out_pc_nxt;
  logic        w_misaligned_nxt;
  logic [31:0] w_fetch_count_nxt;
  logic        w_fire;
  logic        w_aligned;

  // The output register may be refilled when it is empty or being drained.
  assign w_fire    = !r_out_valid || out_ready;
  assign w_aligned = (redirect_pc[1:0] == 2'b00);

  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_out_valid_nxt   = r_out_valid;
    w_out_instr_nxt   = r_out_instr;
    w_out_pc_nxt      = r_out_pc;
    w_misaligned_nxt  = r_misaligned;
    w_fetch_count_nxt = r_fetch_count;

    unique case (r_state)
      // One dead cycle after reset so the memory's reset-forced read is skipped.
      S_IDLE: w_state_nxt = S_RUN;

      S_RUN: begin
        if (redirect_valid) begin
          // Redirect outranks capture: flush whatever sits in IF/ID.
          w_out_valid_nxt = 1'b0;
          if (w_aligned) begin
            w_pc_nxt = redirect_pc;
          end else begin
            w_misaligned_nxt = 1'b1;
            w_state_nxt      = S_HALT;
          end
        end else if (w_fire) begin
          w_out_instr_nxt   = RD;
          w_out_pc_nxt      = r_pc;
          w_out_valid_nxt   = 1'b1;
          w_fetch_count_nxt = r_fetch_count + 32'd1;
          if (RD == HALT_INSN) begin
            // The halt word is delivered but the pc stays on it.
            w_state_nxt = S_HALT;
          end else begin
            w_pc_nxt = r_pc + 32'd4;
          end
        end
      end

      S_HALT: begin
        if (redirect_valid) begin
          w_out_valid_nxt = 1'b0;
          if (w_aligned) begin
            w_pc_nxt    = redirect_pc;
            w_state_nxt = S_RUN;
          end else begin
            w_misaligned_nxt = 1'b1;
          end
        end else if (r_out_valid && out_ready) begin
          // Let decode drain the last captured word, then stay empty.
          w_out_valid_nxt = 1'b0;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_out_valid   <= 1'b0;
      r_out_instr   <= 32'd0;
      r_out_pc      <= 32'd0;
      r_misaligned  <= 1'b0;
      r_fetch_count <= 32'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_out_valid   <= w_out_valid_nxt;
      r_out_instr   <= w_out_instr_nxt;
      r_out_pc      <= w_out_pc_nxt;
      r_misaligned  <= w_misaligned_nxt;
      r_fetch_count <= w_fetch_count_nxt;
    end
  end

  assign A           = r_pc;
  assign out_valid   = r_out_valid;
  assign out_instr   = r_out_instr;
  assign out_pc      = r_out_pc;
  assign halted      = (r_state == S_HALT);
  assign misaligned  = r_misaligned;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A;
  logic [31:0] RD;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;
  logic        misaligned;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [64];
  logic [63:0] exp_q [$];   // {instr, pc} expected at each decode handshake

  localparam logic [31:0] I0   = 32'h0062E233;
  localparam logic [31:0] I1   = 32'h00520533;
  localparam logic [31:0] I2   = 32'h00A02023;
  localparam logic [31:0] IH   = 32'h00000073;
  localparam logic [31:0] I4   = 32'h00B50593;
  localparam logic [31:0] I63  = 32'h00C58613;
  localparam logic [31:0] INOP = 32'h00000013;

  always #5 clk = ~clk;

  assign RD = mem[A[7:2]];

  instruction_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .A              (A),
    .RD             (RD),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted),
    .misaligned     (misaligned),
    .fetch_count    (fetch_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_A"},         A,                  32'h0);
    chk({tag, "_valid"},     {31'd0, out_valid},  32'd0);
    chk({tag, "_instr"},     out_instr,          32'h0);
    chk({tag, "_pc"},        out_pc,             32'h0);
    chk({tag, "_halted"},    {31'd0, halted},     32'd0);
    chk({tag, "_misalign"},  {31'd0, misaligned}, 32'd0);
    chk({tag, "_count"},     fetch_count,        32'd0);
  endtask

  // Monitor: every decode handshake must match the head of the scoreboard.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got instr 0x%08h pc 0x%08h expected none", out_instr, out_pc);
        end else begin
          e = exp_q.pop_front();
          if ({out_instr, out_pc} !== e) begin
            n_fail++;
            $display("FAIL sb_handshake: got instr 0x%08h pc 0x%08h expected instr 0x%08h pc 0x%08h",
                     out_instr, out_pc, e[63:32], e[31:0]);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = INOP;
    mem[0]  = I0;
    mem[1]  = I1;
    mem[2]  = I2;
    mem[3]  = IH;
    mem[4]  = I4;
    mem[63] = I63;

    reset = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    tick(); tick();
    chk_reset_vals("rst0");

    // Streaming fetch into the halt word
    exp_q.push_back({I0, 32'h0});
    exp_q.push_back({I1, 32'h4});
    exp_q.push_back({I2, 32'h8});
    exp_q.push_back({IH, 32'hC});
    reset = 1'b0; out_ready = 1'b1;
    tick();
    chk("idle_A", A, 32'h0);
    chk("idle_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("cap0_valid", {31'd0, out_valid}, 32'd1);
    chk("cap0_instr", out_instr, I0);
    chk("cap0_pc", out_pc, 32'h0);
    chk("cap0_A", A, 32'h4);
    chk("cap0_cnt", fetch_count, 32'd1);
    tick();
    chk("cap1_pc", out_pc, 32'h4);
    chk("cap1_A", A, 32'h8);
    chk("cap1_cnt", fetch_count, 32'd2);
    tick();
    chk("cap2_instr", out_instr, I2);
    chk("cap2_pc", out_pc, 32'h8);
    chk("cap2_A", A, 32'hC);
    chk("cap2_cnt", fetch_count, 32'd3);
    tick();
    chk("halt_instr", out_instr, IH);
    chk("halt_pc", out_pc, 32'hC);
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_A", A, 32'hC);
    chk("halt_cnt", fetch_count, 32'd4);
    tick();
    chk("halt_drain_valid", {31'd0, out_valid}, 32'd0);
    chk("halt_drain_halted", {31'd0, halted}, 32'd1);
    chk("halt_drain_A", A, 32'hC);
    tick();
    chk("halt_frozen_A", A, 32'hC);
    chk("halt_frozen_cnt", fetch_count, 32'd4);

    // Misaligned redirect, then aligned recovery
    redirect_valid = 1'b1; redirect_pc = 32'h12;
    tick();
    redirect_valid = 1'b0;
    chk("mis_flag", {31'd0, misaligned}, 32'd1);
    chk("mis_halted", {31'd0, halted}, 32'd1);
    chk("mis_A", A, 32'hC);
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    tick();
    redirect_valid = 1'b0; out_ready = 1'b0;
    chk("recover_halted", {31'd0, halted}, 32'd0);
    chk("recover_A", A, 32'h0);
    chk("recover_mis", {31'd0, misaligned}, 32'd1);
    chk("recover_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("recover_cap_pc", out_pc, 32'h0);
    chk("recover_cap_valid", {31'd0, out_valid}, 32'd1);
    chk("recover_cnt", fetch_count, 32'd5);

    // Reset with a pending word
    reset = 1'b1;
    tick();
    chk_reset_vals("rst1");

    // Back-pressure then redirect
    exp_q.push_back({I0, 32'h0});
    exp_q.push_back({I1, 32'h4});
    reset = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    chk("stall_cap_pc", out_pc, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_instr", out_instr, I0);
      chk("stall_pc", out_pc, 32'h0);
      chk("stall_A", A, 32'h4);
      chk("stall_cnt", fetch_count, 32'd1);
    end
    out_ready = 1'b1;
    tick();
    chk("resume_pc", out_pc, 32'h4);
    chk("resume_A", A, 32'h8);
    chk("resume_cnt", fetch_count, 32'd2);
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    tick();
    redirect_valid = 1'b0;
    chk("redir_valid", {31'd0, out_valid}, 32'd0);
    chk("redir_A", A, 32'h10);
    chk("redir_cnt", fetch_count, 32'd2);
    tick();
    out_ready = 1'b0;
    chk("redir_tgt_valid", {31'd0, out_valid}, 32'd1);
    chk("redir_tgt_pc", out_pc, 32'h10);
    chk("redir_tgt_instr", out_instr, I4);
    chk("redir_tgt_A", A, 32'h14);
    redirect_valid = 1'b1; redirect_pc = 32'h4;
    tick();
    redirect_valid = 1'b0;
    chk("redir2_valid", {31'd0, out_valid}, 32'd0);
    chk("redir2_A", A, 32'h4);
    tick();
    chk("redir2_pc", out_pc, 32'h4);
    tick();
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("pre_rst_A", A, 32'h8);
    reset = 1'b1;
    tick();
    chk_reset_vals("rst2");

    // Redirect ignored in IDLE; pc wrap at top of address space
    exp_q.push_back({I63, 32'hFFFF_FFFC});
    reset = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    chk("idle_redir_A", A, 32'h0);
    tick();
    chk("wrap_first_pc", out_pc, 32'h0);
    chk("wrap_first_A", A, 32'h4);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0; out_ready = 1'b1;
    chk("wrap_redir_A", A, 32'hFFFF_FFFC);
    chk("wrap_redir_cnt", fetch_count, 32'd1);
    tick();
    chk("wrap_cap_pc", out_pc, 32'hFFFF_FFFC);
    chk("wrap_cap_instr", out_instr, I63);
    chk("wrap_A", A, 32'h0);
    chk("wrap_cnt", fetch_count, 32'd2);
    tick();
    out_ready = 1'b0;
    chk("wrap_next_pc", out_pc, 32'h0);
    chk("wrap_next_A", A, 32'h4);
    tick();
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
